// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words read out of the FIFO.
interface fifo_rd_stream_if #(
   parameter int W = 16
);
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready;

   // Producer side: the read adapter drives data and valid.
   modport master (
      output m_data,
      output m_valid,
      input  m_ready
   );

   // Consumer side: downstream logic drives ready.
   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: converts a synchronous FIFO read port (rd_en/empty,
// registered data) into a valid/ready stream. A two-slot buffer absorbs the
// FIFO's one-cycle read latency so a word can be delivered every clock.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   fifo_rd_stream_if.master      m,
   output logic [CNT_WIDTH-1:0]  m_count,
   output logic                  busy
);

   logic [1:0]            occ_reg;
   logic [1:0]            occ_next;
   logic [1:0]            occ_after_pop;
   logic                  inflight_reg;
   logic [FIFO_WIDTH-1:0] head_reg;
   logic [FIFO_WIDTH-1:0] tail_reg;
   logic [CNT_WIDTH-1:0]  count_reg;
   logic                  pop;

   // Handshake, read issue and next occupancy. occ_after_pop + inflight never
   // exceeds 2, so the sum fits in two bits. The read request deliberately
   // looks at m_ready so a slot freed this cycle is refilled immediately.
   always_comb begin
      pop           = (occ_reg != 2'd0) && m.m_ready;
      occ_after_pop = occ_reg - {1'b0, pop};
      occ_next      = occ_after_pop + {1'b0, inflight_reg};
      fifo_rd_en    = rst_n && !fifo_empty &&
                      ((occ_after_pop + {1'b0, inflight_reg}) < 2'd2);
   end

   // Occupancy, in-flight marker and delivered-word counter. A read still in
   // flight at reset is simply forgotten; the FIFO is reset alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         count_reg    <= '0;
      end else begin
         occ_reg      <= occ_next;
         inflight_reg <= fifo_rd_en;
         if (pop) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   // Data slots: a pop shifts tail into head; the arriving FIFO word lands in
   // whichever slot is first free once this edge's pop has been applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         if (pop && (occ_reg == 2'd2)) begin
            head_reg <= tail_reg;
         end
         if (inflight_reg && (occ_after_pop == 2'd0)) begin
            head_reg <= fifo_data_out;
         end
         if (inflight_reg && (occ_after_pop == 2'd1)) begin
            tail_reg <= fifo_data_out;
         end
      end
   end

   assign m.m_valid = (occ_reg != 2'd0);
   assign m.m_data  = head_reg;
   assign m_count   = count_reg;
   assign busy      = (occ_reg != 2'd0) || inflight_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, and a
// reference list of words read-but-not-yet-delivered (each tagged with the
// cycle it becomes available) predicts every output cycle by cycle.
module tb_fifo_rd_stream;
   localparam int W  = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [W-1:0]  fifo_data_out = '0;
   logic          fifo_rd_en;
   logic [CW-1:0] m_count;
   logic          busy;

   fifo_rd_stream_if #(.W(W)) s ();

   fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_rd_en    (fifo_rd_en),
      .m             (s),
      .m_count       (m_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] word;
      int           due;
   } ent_t;

   typedef struct {
      int           nwords;
      logic [W-1:0] base;
      int           rmode;      // 0: ready high, 1: ready low, 2: toggling
      bit           fe;         // force fifo_empty high
      int           ncyc;
      int           exp_reads;
      int           exp_pops;
      int           exp_rd_run;
      int           exp_v_run;
   } vec_t;

   logic [W-1:0]  fifo_q[$];
   ent_t          pend[$];
   int            cyc = 0;
   logic [CW-1:0] exp_count = '0;
   bit            force_empty = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            underflow = 0;
   int            rec_reads, rec_pops, run_rd, max_rd, run_v, max_v;
   vec_t          tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic clear_stats();
      rec_reads = 0; rec_pops = 0; run_rd = 0; max_rd = 0; run_v = 0; max_v = 0;
      underflow = 0;
   endtask

   // One clock: entered just after a rising edge, leaves just after the next.
   task automatic cycle(input bit mr);
      int           avail;
      bit           ev, ep, er, got;
      logic [W-1:0] w;
      s.m_ready  = mr;
      fifo_empty = force_empty || (fifo_q.size() == 0);
      #3;
      avail = 0;
      foreach (pend[i]) if (pend[i].due <= cyc) avail++;
      ev = (avail > 0);
      ep = ev && mr;
      er = !fifo_empty && ((pend.size() - (ep ? 1 : 0)) < 2);
      check("rd_en", 32'(fifo_rd_en), 32'(er));
      check("m_valid", 32'(s.m_valid), 32'(ev));
      if (ev) check("m_data", 32'(s.m_data), 32'(pend[0].word));
      check("m_count", 32'(m_count), 32'(exp_count));
      check("busy", 32'(busy), 32'(pend.size() != 0));
      if (fifo_rd_en && fifo_empty) underflow++;
      if (fifo_rd_en) begin rec_reads++; run_rd++; end else run_rd = 0;
      if (run_rd > max_rd) max_rd = run_rd;
      if (s.m_valid) run_v++; else run_v = 0;
      if (run_v > max_v) max_v = run_v;
      if (s.m_valid && mr) rec_pops++;
      $display("cyc %0d ready=%0b empty=%0b rd_en=%0b valid=%0b data=%04h count=%0d",
               cyc, mr, fifo_empty, fifo_rd_en, s.m_valid, s.m_data, m_count);
      @(posedge clk);
      got = 1'b0;
      w   = '0;
      if (ep) begin
         pend.delete(0);
         exp_count++;
      end
      if (fifo_rd_en && (fifo_q.size() > 0)) begin
         w   = fifo_q.pop_front();
         got = 1'b1;
         pend.push_back('{w, cyc + 2});
      end
      cyc++;
      #1;
      if (got) fifo_data_out = w;
   endtask

   task automatic reset_outputs_check(input string tag);
      check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
      check({tag, "_valid"}, 32'(s.m_valid), 32'd0);
      check({tag, "_data"}, 32'(s.m_data), 32'd0);
      check({tag, "_count"}, 32'(m_count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit mr;
      int guard;
      s.m_ready = 1'b0;

      // Reset held 3 cycles with the FIFO claiming data is available.
      #1 rst_n = 1'b0;
      fifo_empty = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #10;
         reset_outputs_check("reset");
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors; bench state carries over between rows.
      tbl[0] = '{1, 16'hA5A5, 0, 1'b0, 6, 1, 1, 1, 1};
      tbl[1] = '{8, 16'h0001, 0, 1'b0, 14, 8, 8, 8, 8};
      tbl[2] = '{4, 16'h3000, 1, 1'b0, 10, 2, 0, 2, 8};
      tbl[3] = '{0, 16'h0000, 0, 1'b0, 8, 2, 4, 2, 4};
      tbl[4] = '{0, 16'h0000, 2, 1'b1, 20, 0, 0, 0, 0};
      for (int r = 0; r < 5; r++) begin
         clear_stats();
         for (int k = 0; k < tbl[r].nwords; k++) fifo_q.push_back(tbl[r].base + W'(k));
         force_empty = tbl[r].fe;
         for (int k = 0; k < tbl[r].ncyc; k++) begin
            mr = (tbl[r].rmode == 0) ? 1'b1 : (tbl[r].rmode == 1) ? 1'b0 : 1'(k % 2);
            cycle(mr);
         end
         force_empty = 1'b0;
         check($sformatf("vec%0d_reads", r), 32'(rec_reads), 32'(tbl[r].exp_reads));
         check($sformatf("vec%0d_pops", r), 32'(rec_pops), 32'(tbl[r].exp_pops));
         check($sformatf("vec%0d_rd_run", r), 32'(max_rd), 32'(tbl[r].exp_rd_run));
         check($sformatf("vec%0d_valid_run", r), 32'(max_v), 32'(tbl[r].exp_v_run));
         check($sformatf("vec%0d_underflow", r), 32'(underflow), 32'd0);
      end

      // Random pushes and back-pressure; the counter wraps several times.
      clear_stats();
      for (int k = 0; k < 1500; k++) begin
         if (($urandom_range(0, 1) == 1) && (fifo_q.size() < 20)) fifo_q.push_back(W'($urandom));
         cycle($urandom_range(0, 3) != 0);
      end
      check("random_underflow", 32'(underflow), 32'd0);

      // Drain, then reset while one word is buffered and one is in flight.
      guard = 0;
      while (((pend.size() != 0) || (fifo_q.size() != 0)) && (guard < 60)) begin
         cycle(1'b1);
         guard++;
      end
      check("drain_done", 32'(pend.size() + fifo_q.size()), 32'd0);
      fifo_q.push_back(16'hBEEF);
      fifo_q.push_back(16'hCAFE);
      fifo_q.push_back(16'hD00D);
      cycle(1'b0);
      cycle(1'b0);
      check("pre_reset_busy", 32'(busy), 32'd1);
      check("pre_reset_valid", 32'(s.m_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_outputs_check("midrst");
      fifo_q.delete();
      pend.delete();
      exp_count = '0;
      fifo_empty = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         reset_outputs_check("midrst_hold");
      end
      rst_n = 1'b1;
      fifo_q.push_back(16'h1111);
      fifo_q.push_back(16'h2222);
      for (int k = 0; k < 8; k++) cycle(1'b1);
      check("post_reset_count", 32'(m_count), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
